// File: rtl/multi_sync_debounce.sv
// Multi-channel async input synchronizer with per-channel debounce filter,
// registered rise/fall event pulses and per-channel stable flags.
module multi_sync_debounce #(
  parameter int               WIDTH        = 4,
  parameter int               DEPTH        = 2,
  parameter int               STABLE_COUNT = 4,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] stable,
  output logic             all_stable
);

  localparam int SYNC_DEPTH = (DEPTH < 2) ? 2 : DEPTH;
  localparam int NZ_COUNT   = (STABLE_COUNT < 1) ? 1 : STABLE_COUNT;
  localparam int CW         = $clog2(NZ_COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(NZ_COUNT - 1);

  logic [SYNC_DEPTH-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] s;

  // Stage 0 captures din; the last stage feeds the filter.
  assign sync_d = {sync_q[SYNC_DEPTH-2:0], din};
  assign s      = sync_q[SYNC_DEPTH-1];

  always_comb begin
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    rise_d   = '0;
    fall_d   = '0;
    stable_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == dout_q[i]) begin
        cnt_d[i]    = '0;
        stable_d[i] = 1'b1;
      end else if (cnt_q[i] == LAST) begin
        dout_d[i] = s[i];
        cnt_d[i]  = '0;
        rise_d[i] = s[i];
        fall_d[i] = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {SYNC_DEPTH{RESET_VAL}};
      cnt_q    <= '0;
      dout_q   <= RESET_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      stable_q <= '0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      stable_q <= stable_d;
    end
  end

  assign dout       = dout_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign stable     = stable_q;
  assign all_stable = &stable_q;

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Directed bench for multi_sync_debounce: table-driven main vectors
// plus hand sequences for reset values and parameter clamping.
module tb_multi_sync_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [3:0] din_a, din_b, din_c;
  logic [3:0] dout_a, rise_a, fall_a, stab_a;
  logic [3:0] dout_b, rise_b, fall_b, stab_b;
  logic [3:0] dout_c, rise_c, fall_c, stab_c;
  logic       all_a, all_b, all_c;

  multi_sync_debounce #(.WIDTH(4), .DEPTH(2), .STABLE_COUNT(4),
    .RESET_VAL(4'b0101)) dut_a (
    .clk(clk), .reset(rst_a), .din(din_a), .dout(dout_a),
    .rise(rise_a), .fall(fall_a), .stable(stab_a), .all_stable(all_a));

  multi_sync_debounce #(.WIDTH(4), .DEPTH(2), .STABLE_COUNT(4),
    .RESET_VAL(4'b0000)) dut_b (
    .clk(clk), .reset(rst_b), .din(din_b), .dout(dout_b),
    .rise(rise_b), .fall(fall_b), .stable(stab_b), .all_stable(all_b));

  multi_sync_debounce #(.WIDTH(4), .DEPTH(1), .STABLE_COUNT(0),
    .RESET_VAL(4'b0000)) dut_c (
    .clk(clk), .reset(rst_c), .din(din_c), .dout(dout_c),
    .rise(rise_c), .fall(fall_c), .stable(stab_c), .all_stable(all_c));

  typedef struct {
    logic       rst;
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] stab;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t v(input logic r, input logic [3:0] d,
    input logic [3:0] o, input logic [3:0] ri, input logic [3:0] fa,
    input logic [3:0] st);
    vec_t x;
    x.rst = r; x.din = d; x.dout = o;
    x.rise = ri; x.fall = fa; x.stab = st;
    return x;
  endfunction

  task automatic add(input vec_t x, input int n);
    for (int k = 0; k < n; k++) tbl.push_back(x);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act,
    input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input logic [3:0] o,
    input logic [3:0] ri, input logic [3:0] fa, input logic [3:0] st);
    chk({nm, " dout"}, dout_a, o);
    chk({nm, " rise"}, rise_a, ri);
    chk({nm, " fall"}, fall_a, fa);
    chk({nm, " stable"}, stab_a, st);
    chk({nm, " all_stable"}, {3'b0, all_a}, {3'b0, &st});
  endtask

  task automatic chk_c(input string nm, input logic [3:0] o,
    input logic [3:0] ri, input logic [3:0] fa, input logic [3:0] st);
    chk({nm, " dout"}, dout_c, o);
    chk({nm, " rise"}, rise_c, ri);
    chk({nm, " fall"}, fall_c, fa);
    chk({nm, " stable"}, stab_c, st);
    chk({nm, " all_stable"}, {3'b0, all_c}, {3'b0, &st});
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    din_a = 4'b0101; din_b = 4'h0; din_c = 4'h0;

    // reset, idle
    add(v(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0), 2);
    add(v(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF), 2);
    // clean rise on ch1, then clean fall
    add(v(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'hF), 2);
    add(v(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'hD), 3);
    add(v(0, 4'h2, 4'h2, 4'h2, 4'h0, 4'hD), 1);
    add(v(0, 4'h2, 4'h2, 4'h0, 4'h0, 4'hF), 2);
    add(v(0, 4'h0, 4'h2, 4'h0, 4'h0, 4'hF), 2);
    add(v(0, 4'h0, 4'h2, 4'h0, 4'h0, 4'hD), 3);
    add(v(0, 4'h0, 4'h0, 4'h0, 4'h2, 4'hD), 1);
    add(v(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF), 1);
    // 3-cycle glitch on ch2
    add(v(0, 4'h4, 4'h0, 4'h0, 4'h0, 4'hF), 2);
    add(v(0, 4'h4, 4'h0, 4'h0, 4'h0, 4'hB), 1);
    add(v(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hB), 2);
    add(v(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF), 2);
    // simultaneous ch0/ch3, ch3 drops early
    add(v(0, 4'h9, 4'h0, 4'h0, 4'h0, 4'hF), 2);
    add(v(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h6), 2);
    add(v(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'hE), 1);
    add(v(0, 4'h1, 4'h1, 4'h1, 4'h0, 4'hE), 1);
    add(v(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF), 1);
    add(v(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'hF), 2);
    add(v(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'hE), 3);
    add(v(0, 4'h0, 4'h0, 4'h0, 4'h1, 4'hE), 1);
    add(v(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF), 1);
    // reset in the middle of a ch1 count
    add(v(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'hF), 2);
    add(v(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'hD), 1);
    add(v(1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0), 1);
    add(v(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'hF), 2);
    add(v(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'hD), 3);
    add(v(0, 4'h2, 4'h2, 4'h2, 4'h0, 4'hD), 1);
    add(v(0, 4'h2, 4'h2, 4'h0, 4'h0, 4'hF), 1);

    // reset values with a non-zero RESET_VAL
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_a($sformatf("rstval c%0d", k), 4'b0101, 4'h0, 4'h0, 4'h0);
    end
    rst_a = 1'b0;
    tick();
    chk_a("rstval release", 4'b0101, 4'h0, 4'h0, 4'hF);

    // main table
    for (int i = 0; i < tbl.size(); i++) begin
      rst_b = tbl[i].rst;
      din_b = tbl[i].din;
      tick();
      chk($sformatf("row%0d dout", i), dout_b, tbl[i].dout);
      chk($sformatf("row%0d rise", i), rise_b, tbl[i].rise);
      chk($sformatf("row%0d fall", i), fall_b, tbl[i].fall);
      chk($sformatf("row%0d stable", i), stab_b, tbl[i].stab);
      chk($sformatf("row%0d all_stable", i), {3'b0, all_b},
        {3'b0, &tbl[i].stab});
    end

    // clamped DEPTH=1, STABLE_COUNT=0
    tick();
    rst_c = 1'b0;
    tick();
    chk_c("clamp idle", 4'h0, 4'h0, 4'h0, 4'hF);
    din_c = 4'h8;
    tick();
    chk_c("clamp rise e0", 4'h0, 4'h0, 4'h0, 4'hF);
    tick();
    chk_c("clamp rise e1", 4'h0, 4'h0, 4'h0, 4'hF);
    tick();
    chk_c("clamp rise e2", 4'h8, 4'h8, 4'h0, 4'h7);
    tick();
    chk_c("clamp rise e3", 4'h8, 4'h0, 4'h0, 4'hF);
    din_c = 4'h0;
    tick();
    chk_c("clamp fall e0", 4'h8, 4'h0, 4'h0, 4'hF);
    tick();
    chk_c("clamp fall e1", 4'h8, 4'h0, 4'h0, 4'hF);
    tick();
    chk_c("clamp fall e2", 4'h0, 4'h0, 4'h8, 4'h7);
    tick();
    chk_c("clamp fall e3", 4'h0, 4'h0, 4'h0, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
